// File: rtl/jk_mod_counter_if.sv
// jk_mod_counter_if: control inputs and count outputs of the modulo-N JK counter
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en_i;
  logic             up_i;
  logic             load_i;
  logic [WIDTH-1:0] d_i;
  logic [WIDTH-1:0] q_o;
  logic             tc_o;
  logic             wrap_o;
  modport master (output en_i, up_i, load_i, d_i, input q_o, tc_o, wrap_o);
  modport slave  (input en_i, up_i, load_i, d_i, output q_o, tc_o, wrap_o);
endinterface

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-N up/down counter built from JK toggle stages with load, TC and WRAP
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic             clk,
  input logic             rst,
  jk_mod_counter_if.slave bus
);
  localparam logic [WIDTH:0] MOD  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d, j, k;
  logic             wrap_q, tc, at_top, at_zero, d_ok;
  always_comb begin
    at_top  = {1'b0, q_q} == LAST;
    at_zero = q_q == '0;
    d_ok    = {1'b0, bus.d_i} < MOD;
    tc      = bus.en_i & ~bus.load_i & ((bus.up_i & at_top) | (~bus.up_i & at_zero));
    q_d     = bus.load_i ? (d_ok ? bus.d_i : LAST[WIDTH-1:0]) :
              ~bus.en_i  ? q_q :
              bus.up_i   ? (at_top ? '0 : q_q + WIDTH'(1)) :
                           (at_zero ? LAST[WIDTH-1:0] : q_q - WIDTH'(1));
    j       = q_q ^ q_d;
    k       = q_q ^ q_d;
  end
  // each bit is a JK stage: Q+ = J&~Q | ~K&Q with J = K = toggle term
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= (j & ~q_q) | (~k & q_q);
      wrap_q <= tc;
    end
  end
  assign bus.q_o    = q_q;
  assign bus.tc_o   = tc;
  assign bus.wrap_o = wrap_q;
endmodule
